// File: rtl/rv_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_wb_pkg
//  Description : Shared constants for the write-back / retire stage:
//                wb_sel encodings, fflags bit positions and the NaN-box pad.
//  Revision    : 1.0  initial release
// ============================================================================
package rv_wb_pkg;

    // Write-back source select encodings (3-bit)
    localparam logic [2:0] WB_SEL_ALU    = 3'b000;
    localparam logic [2:0] WB_SEL_MEM    = 3'b001;
    localparam logic [2:0] WB_SEL_PC4    = 3'b010;
    localparam logic [2:0] WB_SEL_CSR    = 3'b011;
    localparam logic [2:0] WB_SEL_MULDIV = 3'b100;
    localparam logic [2:0] WB_SEL_AMO    = 3'b101;
    localparam logic [2:0] WB_SEL_FPINT  = 3'b110;
    localparam logic [2:0] WB_SEL_ZERO   = 3'b111;

    // Bit positions inside the 5-bit {nv,dz,of,uf,nx} flag vector
    localparam int FFLAG_NV = 4;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_NX = 0;

    // Upper half written above a single-precision value in a 64-bit FP reg
    localparam logic [31:0] NANBOX_HI = 32'hFFFF_FFFF;

endpackage : rv_wb_pkg
`default_nettype wire

// File: rtl/wb_data_mux.sv
`default_nettype none
// ============================================================================
//  Module      : wb_data_mux
//  Description : Combinational write-back data selection for the integer and
//                FP register files, including NaN-boxing of single-precision
//                results when the FP register file is 64 bits wide.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_data_mux
    import rv_wb_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int FLEN = 64
) (
    input  logic [2:0]      wb_sel,
    input  logic            fp_fmt,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] mem_read_data,
    input  logic [XLEN-1:0] pc_plus_4,
    input  logic [XLEN-1:0] csr_rdata,
    input  logic [XLEN-1:0] mul_div_result,
    input  logic [XLEN-1:0] atomic_result,
    input  logic [XLEN-1:0] int_result_fp,
    input  logic [FLEN-1:0] fp_result,
    input  logic [FLEN-1:0] fp_mem_read_data,
    output logic [XLEN-1:0] int_wdata,
    output logic [FLEN-1:0] fp_wdata
);

    logic [FLEN-1:0] w_fp_raw;

    // Integer write-back source; the unused encoding writes zero
    always_comb begin
        int_wdata = '0;
        case (wb_sel)
            WB_SEL_ALU:    int_wdata = alu_result;
            WB_SEL_MEM:    int_wdata = mem_read_data;
            WB_SEL_PC4:    int_wdata = pc_plus_4;
            WB_SEL_CSR:    int_wdata = csr_rdata;
            WB_SEL_MULDIV: int_wdata = mul_div_result;
            WB_SEL_AMO:    int_wdata = atomic_result;
            WB_SEL_FPINT:  int_wdata = int_result_fp;
            default:       int_wdata = '0;
        endcase
    end

    // FP loads come from memory, everything else from the FP unit
    always_comb begin
        w_fp_raw = (wb_sel == WB_SEL_MEM) ? fp_mem_read_data : fp_result;
    end

    generate
        if (FLEN == 64) begin : g_nanbox
            // Single-precision values get all-ones in the upper word
            assign fp_wdata = fp_fmt ? w_fp_raw : {NANBOX_HI, w_fp_raw[31:0]};
        end else begin : g_no_nanbox
            // Register is exactly single width; format has no effect
            logic w_fmt_unused;
            assign w_fmt_unused = fp_fmt;
            assign fp_wdata     = w_fp_raw;
        end
    endgenerate

endmodule : wb_data_mux
`default_nettype wire

// File: rtl/wb_retire_unit.sv
`default_nettype none
// ============================================================================
//  Module      : wb_retire_unit
//  Description : Write-back stage behind the MEM/WB pipeline register.
//                Drives integer / FP register-file writes, accumulates the
//                sticky fflags and counts retired instructions (instret).
//                Optional feature macro WB_LATE_BYPASS_EN adds a one-cycle
//                late copy of each integer write for WB->ID forwarding.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_retire_unit
    import rv_wb_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int FLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    input  logic            reg_write_in,
    input  logic            int_reg_write_fp_in,
    input  logic            fp_reg_write_in,
    input  logic            fp_fmt_in,
    input  logic [4:0]      rd_addr_in,
    input  logic [4:0]      fp_rd_addr_in,
    input  logic [2:0]      wb_sel_in,
    input  logic [XLEN-1:0] alu_result_in,
    input  logic [XLEN-1:0] mem_read_data_in,
    input  logic [XLEN-1:0] pc_plus_4_in,
    input  logic [XLEN-1:0] csr_rdata_in,
    input  logic [XLEN-1:0] mul_div_result_in,
    input  logic [XLEN-1:0] atomic_result_in,
    input  logic [XLEN-1:0] int_result_fp_in,
    input  logic [FLEN-1:0] fp_result_in,
    input  logic [FLEN-1:0] fp_mem_read_data_in,
    input  logic [4:0]      fp_flags_in,
    input  logic            fflags_we,
    input  logic            instret_we,
    input  logic [4:0]      fflags_wdata,
    input  logic [63:0]     instret_wdata,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            fp_rf_we,
    output logic [4:0]      fp_rf_waddr,
    output logic [FLEN-1:0] fp_rf_wdata,
    output logic [4:0]      fflags,
    output logic [63:0]     instret,
    output logic            retire,
    output logic            late_valid,
    output logic [4:0]      late_rd,
    output logic [XLEN-1:0] late_data
);

    logic [4:0]  r_fflags;
    logic [63:0] r_instret;
    logic        w_fp_op;
    logic [4:0]  w_new_flags;

    wb_data_mux #(
        .XLEN (XLEN),
        .FLEN (FLEN)
    ) u_wb_data_mux (
        .wb_sel           (wb_sel_in),
        .fp_fmt           (fp_fmt_in),
        .alu_result       (alu_result_in),
        .mem_read_data    (mem_read_data_in),
        .pc_plus_4        (pc_plus_4_in),
        .csr_rdata        (csr_rdata_in),
        .mul_div_result   (mul_div_result_in),
        .atomic_result    (atomic_result_in),
        .int_result_fp    (int_result_fp_in),
        .fp_result        (fp_result_in),
        .fp_mem_read_data (fp_mem_read_data_in),
        .int_wdata        (rf_wdata),
        .fp_wdata         (fp_rf_wdata)
    );

    // Register-file write controls are purely combinational; x0 is never written
    always_comb begin
        rf_we       = valid_in & (reg_write_in | int_reg_write_fp_in) & (rd_addr_in != 5'd0);
        rf_waddr    = rd_addr_in;
        fp_rf_we    = valid_in & fp_reg_write_in;
        fp_rf_waddr = fp_rd_addr_in;
        retire      = valid_in;
    end

    // Flags only count when an FP-producing instruction actually retires
    always_comb begin
        w_fp_op                = valid_in & (fp_reg_write_in | int_reg_write_fp_in);
        w_new_flags            = '0;
        w_new_flags[FFLAG_NV]  = fp_flags_in[FFLAG_NV];
        w_new_flags[FFLAG_DZ]  = fp_flags_in[FFLAG_DZ];
        w_new_flags[FFLAG_OF]  = fp_flags_in[FFLAG_OF];
        w_new_flags[FFLAG_UF]  = fp_flags_in[FFLAG_UF];
        w_new_flags[FFLAG_NX]  = fp_flags_in[FFLAG_NX];
    end

    // Sticky fflags: a CSR write belongs to a younger instruction and wins
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fflags <= '0;
        end else if (fflags_we) begin
            r_fflags <= fflags_wdata;
        end else if (w_fp_op) begin
            r_fflags <= r_fflags | w_new_flags;
        end
    end

    // instret: CSR write wins over a same-cycle retirement; natural 64-bit wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instret <= '0;
        end else if (instret_we) begin
            r_instret <= instret_wdata;
        end else if (valid_in) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign fflags  = r_fflags;
    assign instret = r_instret;

`ifdef WB_LATE_BYPASS_EN
    logic            r_late_valid;
    logic [4:0]      r_late_rd;
    logic [XLEN-1:0] r_late_data;

    // Hold each integer write for one more cycle for ID-stage forwarding
    always_ff @(posedge clk) begin
        if (reset) begin
            r_late_valid <= 1'b0;
            r_late_rd    <= '0;
            r_late_data  <= '0;
        end else begin
            r_late_valid <= rf_we;
            r_late_rd    <= rf_waddr;
            r_late_data  <= rf_wdata;
        end
    end

    assign late_valid = r_late_valid;
    assign late_rd    = r_late_rd;
    assign late_data  = r_late_data;
`else
    assign late_valid = 1'b0;
    assign late_rd    = '0;
    assign late_data  = '0;
`endif

endmodule : wb_retire_unit
`default_nettype wire

// File: tb/tb_wb_retire_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_retire_unit
//  Description : Scoreboard bench for wb_retire_unit (XLEN=64, FLEN=64).
//                Directed scenarios followed by random traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_retire_unit;

    typedef struct {
        logic        rst;
        logic        valid, rw, ifp, fpw, fmt;
        logic [4:0]  rd, frd;
        logic [2:0]  sel;
        logic [63:0] src [8];     // indexed by wb_sel; entry 7 unused
        logic [63:0] fpres, fpmem;
        logic [4:0]  flags;
        logic        fwe, iwe;
        logic [4:0]  fwd;
        logic [63:0] iwd;
    } stim_t;

    typedef struct {
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [63:0] rf_wdata;
        logic        fp_we;
        logic [4:0]  fp_waddr;
        logic [63:0] fp_wdata;
        logic        retire;
        logic [4:0]  fflags;
        logic [63:0] instret;
        logic        lv;
        logic [4:0]  lrd;
        logic [63:0] ldata;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, valid_in, reg_write_in, int_reg_write_fp_in, fp_reg_write_in, fp_fmt_in;
    logic [4:0]  rd_addr_in, fp_rd_addr_in, fp_flags_in, fflags_wdata;
    logic [2:0]  wb_sel_in;
    logic [63:0] alu_result_in, mem_read_data_in, pc_plus_4_in, csr_rdata_in;
    logic [63:0] mul_div_result_in, atomic_result_in, int_result_fp_in;
    logic [63:0] fp_result_in, fp_mem_read_data_in, instret_wdata;
    logic        fflags_we, instret_we;
    logic        rf_we, fp_rf_we, retire, late_valid;
    logic [4:0]  rf_waddr, fp_rf_waddr, fflags, late_rd;
    logic [63:0] rf_wdata, fp_rf_wdata, instret, late_data;

    wb_retire_unit #(.XLEN(64), .FLEN(64)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .reg_write_in(reg_write_in),
        .int_reg_write_fp_in(int_reg_write_fp_in), .fp_reg_write_in(fp_reg_write_in),
        .fp_fmt_in(fp_fmt_in), .rd_addr_in(rd_addr_in), .fp_rd_addr_in(fp_rd_addr_in),
        .wb_sel_in(wb_sel_in), .alu_result_in(alu_result_in), .mem_read_data_in(mem_read_data_in),
        .pc_plus_4_in(pc_plus_4_in), .csr_rdata_in(csr_rdata_in),
        .mul_div_result_in(mul_div_result_in), .atomic_result_in(atomic_result_in),
        .int_result_fp_in(int_result_fp_in), .fp_result_in(fp_result_in),
        .fp_mem_read_data_in(fp_mem_read_data_in), .fp_flags_in(fp_flags_in),
        .fflags_we(fflags_we), .instret_we(instret_we), .fflags_wdata(fflags_wdata),
        .instret_wdata(instret_wdata), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fp_rf_we(fp_rf_we), .fp_rf_waddr(fp_rf_waddr), .fp_rf_wdata(fp_rf_wdata),
        .fflags(fflags), .instret(instret), .retire(retire), .late_valid(late_valid),
        .late_rd(late_rd), .late_data(late_data)
    );

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state
    logic [4:0]  m_fflags  = '0;
    logic [63:0] m_instret = '0;
    logic        m_lv      = 1'b0;
    logic [4:0]  m_lrd     = '0;
    logic [63:0] m_ldata   = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rst = 0; s.valid = 0; s.rw = 0; s.ifp = 0; s.fpw = 0; s.fmt = 1;
        s.rd = 0; s.frd = 0; s.sel = 0;
        for (int i = 0; i < 8; i++) s.src[i] = 64'd0;
        s.fpres = 0; s.fpmem = 0; s.flags = 0;
        s.fwe = 0; s.iwe = 0; s.fwd = 0; s.iwd = 0;
        return s;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic drive(input stim_t s);
        reset = s.rst; valid_in = s.valid; reg_write_in = s.rw;
        int_reg_write_fp_in = s.ifp; fp_reg_write_in = s.fpw; fp_fmt_in = s.fmt;
        rd_addr_in = s.rd; fp_rd_addr_in = s.frd; wb_sel_in = s.sel;
        alu_result_in = s.src[0]; mem_read_data_in = s.src[1]; pc_plus_4_in = s.src[2];
        csr_rdata_in = s.src[3]; mul_div_result_in = s.src[4]; atomic_result_in = s.src[5];
        int_result_fp_in = s.src[6]; fp_result_in = s.fpres; fp_mem_read_data_in = s.fpmem;
        fp_flags_in = s.flags; fflags_we = s.fwe; instret_we = s.iwe;
        fflags_wdata = s.fwd; instret_wdata = s.iwd;
    endtask

    // One cycle: apply inputs, push expectation for this cycle, advance model
    task automatic step(input stim_t s);
        exp_t        e;
        logic [63:0] fpd;
        @(posedge clk);
        #1;
        drive(s);
        e.rf_we    = s.valid && (s.rw || s.ifp) && (s.rd != 0);
        e.rf_waddr = s.rd;
        e.rf_wdata = (s.sel == 3'd7) ? 64'd0 : s.src[s.sel];
        fpd        = (s.sel == 3'd1) ? s.fpmem : s.fpres;
        e.fp_we    = s.valid && s.fpw;
        e.fp_waddr = s.frd;
        e.fp_wdata = s.fmt ? fpd : {32'hFFFF_FFFF, fpd[31:0]};
        e.retire   = s.valid;
        e.fflags   = m_fflags;
        e.instret  = m_instret;
        e.lv       = m_lv;
        e.lrd      = m_lrd;
        e.ldata    = m_ldata;
        q.push_back(e);
        if (s.rst) begin
            m_fflags = 0; m_instret = 0; m_lv = 0; m_lrd = 0; m_ldata = 0;
        end else begin
            if (s.fwe)                          m_fflags = s.fwd;
            else if (s.valid && (s.fpw || s.ifp)) m_fflags = m_fflags | s.flags;
            if (s.iwe)        m_instret = s.iwd;
            else if (s.valid) m_instret = m_instret + 1;
`ifdef WB_LATE_BYPASS_EN
            m_lv = e.rf_we; m_lrd = e.rf_waddr; m_ldata = e.rf_wdata;
`endif
        end
    endtask

    // Monitor: outputs are stable mid-cycle; compare against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rf_we",       {63'd0, rf_we},    {63'd0, e.rf_we});
                chk("rf_waddr",    {59'd0, rf_waddr}, {59'd0, e.rf_waddr});
                chk("rf_wdata",    rf_wdata,          e.rf_wdata);
                chk("fp_rf_we",    {63'd0, fp_rf_we}, {63'd0, e.fp_we});
                chk("fp_rf_waddr", {59'd0, fp_rf_waddr}, {59'd0, e.fp_waddr});
                chk("fp_rf_wdata", fp_rf_wdata,       e.fp_wdata);
                chk("retire",      {63'd0, retire},   {63'd0, e.retire});
                chk("fflags",      {59'd0, fflags},   {59'd0, e.fflags});
                chk("instret",     instret,           e.instret);
                chk("late_valid",  {63'd0, late_valid}, {63'd0, e.lv});
                chk("late_rd",     {59'd0, late_rd},  {59'd0, e.lrd});
                chk("late_data",   late_data,         e.ldata);
            end
        end
    end

    initial begin
        stim_t s;
        s = idle();
        s.rst = 1; s.valid = 1; s.rw = 1; s.rd = 5'd9; s.src[0] = 64'h55;
        drive(s);

        // Reset held two cycles while an instruction presents itself
        step(s);
        step(s);

        // Write to x0 suppressed, then pc+4 write to x5
        s = idle(); s.valid = 1; s.rw = 1; s.rd = 0; s.sel = 3'd0; s.src[0] = 64'h1234;
        step(s);
        s.rd = 5; s.sel = 3'd2; s.src[2] = 64'h8000_0008;
        step(s);

        // FP load single -> NaN-boxed, then double -> unchanged
        s = idle(); s.valid = 1; s.fpw = 1; s.frd = 0; s.fmt = 0; s.sel = 3'd1;
        s.fpmem = 64'h0000_0000_3F80_0000; s.fpres = 64'h1111_2222_3333_4444;
        step(s);
        s.fmt = 1;
        step(s);

        // fflags: accumulate, CSR override, ignored when not valid
        s = idle(); s.valid = 1; s.fpw = 1; s.flags = 5'b00001;
        step(s);
        s.flags = 5'b10000;
        step(s);
        s.fwe = 1; s.fwd = 5'b00000; s.flags = 5'b00100;
        step(s);
        s = idle(); s.fpw = 1; s.flags = 5'b01000;
        step(s);
        s = idle(); s.valid = 1; s.ifp = 1; s.rd = 7; s.sel = 3'd6; s.src[6] = 64'hF00D; s.flags = 5'b00010;
        step(s);

        // instret wrap and CSR-write priority over retirement
        s = idle(); s.iwe = 1; s.iwd = 64'hFFFF_FFFF_FFFF_FFFF;
        step(s);
        s = idle(); s.valid = 1;
        step(s);
        s.iwe = 1; s.iwd = 64'd7;
        step(s);
        s = idle();
        step(s);

        // Late bypass: write x3 then idle
        s = idle(); s.valid = 1; s.rw = 1; s.rd = 3; s.sel = 3'd0; s.src[0] = 64'hABCD;
        step(s);
        s = idle();
        step(s);
        step(s);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            s.rst   = ($urandom_range(0, 63) == 0);
            s.valid = ($urandom_range(0, 3) != 0);
            s.rw    = $urandom_range(0, 1);
            s.ifp   = ($urandom_range(0, 3) == 0);
            s.fpw   = $urandom_range(0, 1);
            s.fmt   = $urandom_range(0, 1);
            s.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            s.frd   = 5'($urandom_range(0, 31));
            s.sel   = 3'($urandom_range(0, 7));
            for (int i = 0; i < 8; i++) s.src[i] = rnd64();
            s.fpres = rnd64();
            s.fpmem = rnd64();
            s.flags = 5'($urandom_range(0, 31));
            s.fwe   = ($urandom_range(0, 15) == 0);
            s.fwd   = 5'($urandom_range(0, 31));
            s.iwe   = ($urandom_range(0, 15) == 0);
            s.iwd   = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFE : rnd64();
            step(s);
        end

        // Let the monitor drain, bounded
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_wb_retire_unit
`default_nettype wire
